// File: rtl/attack_column_selector.sv
// Attack column selector: steps a column index with NEXT/PREV, confirms it to game
// control over a VALID/ACK handshake and shows the column letter on a 7-segment digit.
module attack_column_selector #(
    parameter int NUM_COLS = 5,
    parameter int COL_W    = 3,
    parameter int BLINK_W  = 22
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ENABLE,
    input  logic                BTN_NEXT,
    input  logic                BTN_PREV,
    input  logic                BTN_CONFIRM,
    input  logic [NUM_COLS-1:0] USED_MASK,
    input  logic                ACK,
    output logic [COL_W-1:0]    COL,
    output logic                COL_VALID,
    output logic                REJECT,
    output logic                SEGA,
    output logic                SEGB,
    output logic                SEGC,
    output logic                SEGD,
    output logic                SEGE,
    output logic                SEGF,
    output logic                SEGG
);

    typedef enum logic [1:0] {IDLE, SELECT, WAIT_ACK} state_t;

    localparam int BN = 0;
    localparam int BP = 1;
    localparam int BC = 2;

    state_t             state;
    logic [2:0]         btn_raw;
    logic [2:0]         sync1;
    logic [2:0]         sync2;
    logic [2:0]         prev;
    logic [2:0]         armed;
    logic [2:0]         btn_edge;
    logic [1:0]         settle_cnt;
    logic               settled;
    logic [BLINK_W-1:0] blink_cnt;
    logic               used_cur;
    logic [6:0]         lit;

    assign btn_raw = {BTN_CONFIRM, BTN_PREV, BTN_NEXT};
    assign settled = (settle_cnt == 2'd2);

    // A button only arms once the synchronizer has been refilled after reset and
    // has seen it low, so a button held across reset release never fires.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1      <= '0;
            sync2      <= '0;
            prev       <= '0;
            armed      <= '0;
            settle_cnt <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            prev  <= sync2;
            if (!settled)
                settle_cnt <= settle_cnt + 2'd1;
            else
                armed <= armed | ~sync2;
        end
    end

    assign btn_edge = sync2 & ~prev & armed;

    always_comb begin
        used_cur = 1'b0;
        for (int i = 0; i < NUM_COLS; i++)
            if (int'(COL) == i)
                used_cur = USED_MASK[i];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            COL       <= '0;
            COL_VALID <= 1'b0;
            REJECT    <= 1'b0;
            blink_cnt <= '0;
        end else begin
            REJECT <= 1'b0;
            case (state)
                IDLE: begin
                    if (ENABLE)
                        state <= SELECT;
                end
                SELECT: begin
                    if (!ENABLE) begin
                        state <= IDLE;
                    end else if (btn_edge[BC]) begin
                        if (used_cur) begin
                            REJECT <= 1'b1;
                        end else begin
                            state     <= WAIT_ACK;
                            COL_VALID <= 1'b1;
                            blink_cnt <= '0;
                        end
                    end else if (btn_edge[BN] && !btn_edge[BP]) begin
                        if (COL == COL_W'(NUM_COLS - 1))
                            COL <= '0;
                        else
                            COL <= COL + 1'b1;
                    end else if (btn_edge[BP] && !btn_edge[BN]) begin
                        if (COL == '0)
                            COL <= COL_W'(NUM_COLS - 1);
                        else
                            COL <= COL - 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (!ENABLE || ACK) begin
                        state     <= IDLE;
                        COL_VALID <= 1'b0;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    COL_VALID <= 1'b0;
                end
            endcase
        end
    end

    // lit = {a,b,c,d,e,f,g}, 1 = segment on
    always_comb begin
        lit = 7'b0000000;
        if (state == SELECT || (state == WAIT_ACK && !blink_cnt[BLINK_W-1])) begin
            if (int'(COL) < NUM_COLS) begin
                case (int'(COL))
                    0:       lit = 7'b1110111;
                    1:       lit = 7'b0011111;
                    2:       lit = 7'b1001110;
                    3:       lit = 7'b0111101;
                    4:       lit = 7'b1001111;
                    5:       lit = 7'b1000111;
                    6:       lit = 7'b1011110;
                    7:       lit = 7'b0110111;
                    default: lit = 7'b0000000;
                endcase
            end
        end
    end

    assign {SEGA, SEGB, SEGC, SEGD, SEGE, SEGF, SEGG} = ~lit;

endmodule

// File: doc/attack_column_selector.md
Name: attack_column_selector

Overview:
Sequential successor to the combinational column-letter decoder. The player steps through attack columns with NEXT/PREV buttons and confirms one; the block shows the current column letter on a 7-segment digit. The confirmed column goes to game control through a VALID/ACK handshake. Column count is parametrised, wrap-around is supported, and already-attacked columns are rejected.

Parameters:
NUM_COLS, 5, number of selectable columns, legal range 2..8; letters shown are A,b,C,d,E,F,G,H for indices 0..7.
COL_W, 3, width of the COL output; must satisfy 2^COL_W >= NUM_COLS.
BLINK_W, 22, width of the blink counter; the display toggles every 2^(BLINK_W-1) cycles while in WAIT_ACK.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous reset, active-high.
ENABLE  input  1  player's turn active; level-sensitive.
BTN_NEXT  input  1  raw button, active-high, asynchronous to CLK.
BTN_PREV  input  1  raw button, active-high, asynchronous to CLK.
BTN_CONFIRM  input  1  raw button, active-high, asynchronous to CLK.
USED_MASK  input  NUM_COLS  bit i set = column i already attacked.
ACK  input  1  game control accepts the confirmed column.
COL  output  COL_W  current column index.
COL_VALID  output  1  confirmed column is presented on COL.
REJECT  output  1  one-cycle pulse: confirm attempted on a used column.
SEGA..SEGG  output  1 each  7-segment drive, active-low (0 = segment lit).

Behaviour:
- Reset (async, RST=1): state IDLE, COL=0, COL_VALID=0, REJECT=0, all SEG=1 (blank), synchronizers and blink counter cleared.
- Input conditioning:
  - Each button passes through a 2-flop synchronizer followed by a rising-edge detector (sync2 & ~prev).
  - Any action takes effect on the 3rd rising CLK edge after the raw input goes high, counting the sampling edge as the 1st.
  - A held button produces exactly one action.
- States:
  - IDLE:
    - Display blank; all button edges ignored.
    - ENABLE=1 -> SELECT on the next edge. COL keeps its last value.
  - SELECT:
    - Display shows the letter for COL, steady.
    - NEXT edge: COL = COL+1, with NUM_COLS-1 wrapping to 0.
    - PREV edge: COL = COL-1, with 0 wrapping to NUM_COLS-1.
    - NEXT and PREV edges in the same cycle: no move.
    - CONFIRM has priority over NEXT/PREV in the same cycle:
      - USED_MASK[COL]=0: go to WAIT_ACK, COL_VALID=1 on the same edge.
      - USED_MASK[COL]=1: stay in SELECT, REJECT=1 for exactly one cycle, COL unchanged.
    - Stepping does not skip used columns.
  - WAIT_ACK:
    - COL is frozen and COL_VALID is held at 1; all buttons are ignored.
    - Display blinks the letter: lit while blink_cnt[BLINK_W-1]=0, blank otherwise. The counter restarts at 0 on entry.
    - ACK=1 sampled at an edge: COL_VALID=0 and state IDLE on that edge.
  - ENABLE=0 in SELECT or WAIT_ACK -> IDLE on the next edge, COL_VALID=0, no transfer. ENABLE has priority over ACK and buttons.
- Handshake rules:
  - COL must not change while COL_VALID=1.
  - ACK while COL_VALID=0 is ignored.
- Letter encoding (segments lit, active-low output):
  - A: a,b,c,e,f,g
  - b: c,d,e,f,g
  - C: a,d,e,f
  - d: b,c,d,e,g
  - E: a,d,e,f,g
  - F: a,e,f,g
  - G: a,c,d,e,f
  - H: b,c,e,f,g
  - COL >= NUM_COLS cannot occur; the decoder outputs blank for it.
- RST asserted mid-operation: immediate return to reset values, no pending action survives. A button still held at RST release does not fire until it is released and pressed again.

Test Plan:
1. Reset, ENABLE=1, NUM_COLS=5: SEG shows A (SEGA..G=0,0,0,1,0,0,0); four NEXT presses -> COL=1,2,3,4 with letters b,C,d,E; fifth NEXT -> COL=0 (wrap).
2. From COL=0 one PREV -> COL=4; NEXT and PREV synchronized into the same cycle -> COL stays 4. Held NEXT for 100 cycles -> exactly one increment.
3. COL=2, USED_MASK=5'b00100, CONFIRM -> REJECT high exactly 1 cycle, COL_VALID=0, state SELECT; NEXT then CONFIRM -> COL_VALID=1, COL=3.
4. In WAIT_ACK, press NEXT/PREV -> COL stays 3; with BLINK_W=4 segments toggle lit/blank every 8 cycles; ACK=1 -> COL_VALID=0 at that edge, display blank next cycle.
5. COL_VALID=1, drop ENABLE -> COL_VALID=0 next edge and no ACK is needed; re-enable -> SELECT with COL=3 retained.
6. RST pulsed mid-WAIT_ACK, asynchronous to CLK -> outputs immediately COL=0, COL_VALID=0, SEG all 1; CONFIRM held through RST release causes no confirm.
